axicb_slv_switch_wr_arb: RTL

Slave-side write switch, directly downstream of the master-side write switches. Merges the per-master AW/W/B channels aimed at one slave agent into a single AXI write interface toward that slave.
- AW: round-robin arbitration among masters.
- W: routed in AW grant order using a FIFO of granted master indices.
- B: routed back to the owning master by ID mask.

---
 rtl/axicb_pkg.sv | 33 +++
 rtl/axicb_round_robin.sv | 66 ++++++
 rtl/axicb_scfifo.sv | 70 +++++++
 rtl/axicb_slv_switch_wr_arb.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/axicb_pkg.sv
// axicb_pkg
// Shared definitions for the AXI crossbar switch blocks:
//   - fixed channel field offsets (address in AW, ID in B)
//   - helpers for offsets that depend on the configured widths
//   - one-hot to binary index conversion
package axicb_pkg;

  // Address is the first field of the AW payload, ID the first field of B.
  localparam int AW_ADDR_LSB = 0;
  localparam int B_ID_LSB    = 0;

  // The AW ID sits right above the address field.
  function automatic int unsigned aw_id_lsb(input int unsigned addr_w);
    return addr_w;
  endfunction

  // The B response code sits right above the ID field.
  function automatic int unsigned b_resp_lsb(input int unsigned id_w);
    return id_w;
  endfunction

  // Returns the index of the set bit in a one-hot vector (highest set bit
  // if the vector is not one-hot, 0 when empty).
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/axicb_round_robin.sv
// axicb_round_robin
// Four-requester round-robin arbiter with static priority levels.
// Among the requesters at the highest active priority level, the grant goes
// to the first one above the last granted index, wrapping around.
// Ports:
//   aclk, aresetn (async active-low), srst (sync active-high)
//   en    - advance the round-robin pointer using the current grant
//   req   - request vector
//   grant - one-hot grant (combinational from req and pointer state)
module axicb_round_robin #(
  parameter int REQ0_PRIORITY = 0,
  parameter int REQ1_PRIORITY = 0,
  parameter int REQ2_PRIORITY = 0,
  parameter int REQ3_PRIORITY = 0
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       srst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] grant
);

  localparam int PRIO [4] = '{REQ0_PRIORITY, REQ1_PRIORITY, REQ2_PRIORITY, REQ3_PRIORITY};

  logic [3:0] mask;
  logic [3:0] eligible;
  logic [3:0] masked;
  logic [3:0] pick;
  logic [3:0] next_mask;
  int         top_prio;
  logic       found;

  always_comb begin
    top_prio = 0;
    found    = 1'b0;
    eligible = '0;
    for (int i = 0; i < 4; i++) begin
      if (req[i] && (!found || PRIO[i] > top_prio)) begin
        top_prio = PRIO[i];
        found    = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      eligible[i] = req[i] && (PRIO[i] == top_prio);
    end
    // Prefer requesters above the last grant; wrap to the full set otherwise.
    masked = eligible & mask;
    pick   = (|masked) ? masked : eligible;
    // Isolate the lowest set bit.
    grant  = pick & (~pick + 4'd1);
    // Bits strictly above the granted index; zero when index 3 was granted.
    next_mask = ~((grant << 1) - 4'd1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mask <= '1;
    end else if (srst) begin
      mask <= '1;
    end else if (en && (|grant)) begin
      mask <= next_mask;
    end
  end

endmodule

// File: rtl/axicb_scfifo.sv
// axicb_scfifo
// Single-clock FIFO with full/empty flags and optional pass-through.
// Ports:
//   aclk, aresetn (async active-low), srst (sync active-high)
//   data_in/push/full  - write side, pushes while full are dropped
//   data_out/pop/empty - read side, data_out shows the head entry
// With PASS_THRU != 0 a push into an empty FIFO is visible on data_out in
// the same cycle and may be consumed by a simultaneous pop.
module axicb_scfifo #(
  parameter int PASS_THRU  = 0,
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  pop,
  output logic                  empty
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  store_empty;
  logic                  bypass;
  logic                  do_write;
  logic                  do_read;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign store_empty = (wr_ptr == rd_ptr);
  assign full = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  if (PASS_THRU != 0) begin : g_pass
    assign bypass   = store_empty & push & pop;
    assign empty    = store_empty & !push;
    assign data_out = store_empty ? data_in : mem[rd_ptr[ADDR_WIDTH-1:0]];
  end else begin : g_reg
    assign bypass   = 1'b0;
    assign empty    = store_empty;
    assign data_out = mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

  assign do_write = push & !full & !bypass;
  assign do_read  = pop & !store_empty;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (do_write) mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
  end

endmodule

// File: rtl/axicb_slv_switch_wr_arb.sv
// axicb_slv_switch_wr_arb
// Slave-side write switch: merges the AW/W/B channels of MST_NB masters
// aimed at one slave into a single AXI write interface.
// Ports:
//   aclk, aresetn (async active-low), srst (sync active-high)
//   i_aw*/i_w*/i_b*  - per-master channels (i_bch broadcast to all masters)
//   o_aw*/o_w*/o_b*  - single channel set toward the slave
// AW is round-robin arbitrated, W follows AW grant order through a FIFO of
// one-hot master indices, and B is routed back by ID ownership mask.
module axicb_slv_switch_wr_arb #(
  parameter int                  AXI_ADDR_W      = 8,
  parameter int                  AXI_ID_W        = 8,
  parameter int                  MST_NB          = 4,
  parameter logic [AXI_ID_W-1:0] MST0_ID_MASK    = 'h10,
  parameter logic [AXI_ID_W-1:0] MST1_ID_MASK    = 'h20,
  parameter logic [AXI_ID_W-1:0] MST2_ID_MASK    = 'h30,
  parameter logic [AXI_ID_W-1:0] MST3_ID_MASK    = 'h40,
  parameter int                  MST0_PRIORITY   = 0,
  parameter int                  MST1_PRIORITY   = 0,
  parameter int                  MST2_PRIORITY   = 0,
  parameter int                  MST3_PRIORITY   = 0,
  parameter int                  SLV_OSTDREQ_NUM = 4,
  parameter int                  AWCH_W          = 8,
  parameter int                  WCH_W           = 8,
  parameter int                  BCH_W           = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     srst,
  input  logic [MST_NB-1:0]        i_awvalid,
  output logic [MST_NB-1:0]        i_awready,
  input  logic [MST_NB*AWCH_W-1:0] i_awch,
  input  logic [MST_NB-1:0]        i_wvalid,
  output logic [MST_NB-1:0]        i_wready,
  input  logic [MST_NB-1:0]        i_wlast,
  input  logic [MST_NB*WCH_W-1:0]  i_wch,
  output logic [MST_NB-1:0]        i_bvalid,
  input  logic [MST_NB-1:0]        i_bready,
  output logic [BCH_W-1:0]         i_bch,
  output logic                     o_awvalid,
  input  logic                     o_awready,
  output logic [AWCH_W-1:0]        o_awch,
  output logic                     o_wvalid,
  input  logic                     o_wready,
  output logic                     o_wlast,
  output logic [WCH_W-1:0]         o_wch,
  input  logic                     o_bvalid,
  output logic                     o_bready,
  input  logic [BCH_W-1:0]         o_bch
);

  import axicb_pkg::*;

  localparam int IDX_W   = $clog2(MST_NB);
  localparam int FIFO_AW = $clog2(SLV_OSTDREQ_NUM);
  localparam logic [AXI_ID_W-1:0] ID_MASK [4] =
    '{MST0_ID_MASK, MST1_ID_MASK, MST2_ID_MASK, MST3_ID_MASK};

  logic [MST_NB-1:0] arb_req;
  logic [MST_NB-1:0] arb_grant;
  logic [MST_NB-1:0] grant;
  logic [MST_NB-1:0] grant_r;
  logic              locked;
  logic              aw_hs;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [MST_NB-1:0] fifo_head;
  logic [IDX_W-1:0]  head_idx;
  logic [AXI_ID_W-1:0] b_id;
  logic [MST_NB-1:0] b_sel;
  logic              b_hit;

  // ---------------------------------------------------------------- AW ----
  // While locked the arbiter only sees the locked master, so its grant and
  // its pointer update stay consistent with the grant already presented.
  assign arb_req = locked ? (grant_r & i_awvalid)
                          : (i_awvalid & {MST_NB{!fifo_full}});

  axicb_round_robin #(
    .REQ0_PRIORITY (MST0_PRIORITY),
    .REQ1_PRIORITY (MST1_PRIORITY),
    .REQ2_PRIORITY (MST2_PRIORITY),
    .REQ3_PRIORITY (MST3_PRIORITY)
  ) u_arb (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .en      (aw_hs),
    .req     (arb_req),
    .grant   (arb_grant)
  );

  assign grant     = locked ? grant_r : arb_grant;
  assign o_awvalid = (|(grant & i_awvalid)) & !fifo_full;
  assign i_awready = grant & {MST_NB{o_awready & !fifo_full}};
  assign aw_hs     = o_awvalid & o_awready;

  always_comb begin
    o_awch = '0;
    for (int k = 0; k < MST_NB; k++) begin
      if (grant[k]) o_awch = o_awch | i_awch[k*AWCH_W +: AWCH_W];
    end
  end

  // Hold the grant from the first stalled cycle until the handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      locked  <= 1'b0;
      grant_r <= '0;
    end else if (srst) begin
      locked  <= 1'b0;
      grant_r <= '0;
    end else if (aw_hs) begin
      locked  <= 1'b0;
    end else if (o_awvalid) begin
      locked  <= 1'b1;
      grant_r <= grant;
    end
  end

  // ----------------------------------------------------------------- W ----
  axicb_scfifo #(
    .PASS_THRU  (0),
    .ADDR_WIDTH (FIFO_AW),
    .DATA_WIDTH (MST_NB)
  ) u_wfifo (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .srst     (srst),
    .data_in  (grant),
    .push     (aw_hs),
    .full     (fifo_full),
    .data_out (fifo_head),
    .pop      (fifo_pop),
    .empty    (fifo_empty)
  );

  assign head_idx = IDX_W'(onehot_to_idx(32'(fifo_head)));
  assign o_wvalid = !fifo_empty & i_wvalid[head_idx];
  assign o_wlast  = !fifo_empty & i_wlast[head_idx];
  assign o_wch    = fifo_empty ? '0 : i_wch[head_idx*WCH_W +: WCH_W];
  assign i_wready = fifo_empty ? '0 : (fifo_head & {MST_NB{o_wready}});
  assign fifo_pop = o_wvalid & o_wready & o_wlast;

  // ----------------------------------------------------------------- B ----
  assign b_id = o_bch[B_ID_LSB +: AXI_ID_W];

  // Lowest-index owner wins when masks overlap.
  always_comb begin
    b_sel = '0;
    b_hit = 1'b0;
    for (int k = 0; k < MST_NB; k++) begin
      if (!b_hit && ((b_id & ID_MASK[k]) == ID_MASK[k])) begin
        b_sel[k] = 1'b1;
        b_hit    = 1'b1;
      end
    end
  end

  assign i_bvalid = b_sel & {MST_NB{o_bvalid}};
  assign i_bch    = o_bch;
  // Responses with no owner are sunk so the slave never stalls on them.
  assign o_bready = b_hit ? (|(b_sel & i_bready)) : 1'b1;

endmodule
